// File: rtl/chiplet_types_pkg.sv
// Shared types for the chiplet switch: allocator outport state and index-width helper.
package chiplet_types_pkg;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

  // Index width that never collapses to zero for single-entry vectors.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter
  import chiplet_types_pkg::*;
#(
  parameter  int unsigned N = 5,
  localparam int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_c,
  output logic [W-1:0] idx_c,
  output logic         valid_c
);

  int unsigned j;

  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!valid_c && req[W'(j)]) begin
        valid_c = 1'b1;
        idx_c   = W'(j);
      end
    end
    if (valid_c) gnt_c[idx_c] = 1'b1;
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-outport round-robin switch allocator with packet-long locks.
// Optional lock watchdog (TIMEOUT parameter, timeout_err port) under SWITCH_ALLOC_WATCHDOG_EN.
module switch_allocator
  import chiplet_types_pkg::*;
#(
  parameter  int unsigned NUM_BUFFERS  = 5,
  parameter  int unsigned NUM_OUTPORTS = 5,
`ifdef SWITCH_ALLOC_WATCHDOG_EN
  parameter  int unsigned TIMEOUT      = 1024,
`endif
  localparam int unsigned BW  = idx_width(NUM_BUFFERS),
  localparam int unsigned OPW = idx_width(NUM_OUTPORTS)
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic [NUM_BUFFERS-1:0]                 req_switch,
  input  logic [NUM_BUFFERS-1:0][OPW-1:0]        switch_outport,
  input  logic [NUM_BUFFERS-1:0]                 packet_done,
  input  logic [NUM_OUTPORTS-1:0]                outport_credit,
  output logic [NUM_BUFFERS-1:0]                 switch_granted,
  output logic [NUM_OUTPORTS-1:0]                outport_busy,
  output logic [NUM_OUTPORTS-1:0][BW-1:0]        outport_owner
`ifdef SWITCH_ALLOC_WATCHDOG_EN
  ,
  output logic [NUM_OUTPORTS-1:0]                timeout_err
`endif
);

`ifdef SWITCH_ALLOC_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [NUM_OUTPORTS-1:0][CW-1:0] cnt_q, cnt_n;
  logic [NUM_OUTPORTS-1:0]         err_n;
`endif

  alloc_state_t                      state_q [NUM_OUTPORTS];
  alloc_state_t                      state_n [NUM_OUTPORTS];
  logic [NUM_OUTPORTS-1:0][BW-1:0]   owner_n;
  logic [NUM_OUTPORTS-1:0][BW-1:0]   rr_q, rr_n;
  logic [NUM_BUFFERS-1:0]            gnt_n;

  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] cand_c;
  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] arb_gnt_c;
  logic [NUM_OUTPORTS-1:0][BW-1:0]          arb_idx_c;
  logic [NUM_OUTPORTS-1:0]                  arb_valid_c;

  // Out-of-range outport requests match no candidate vector and are never granted.
  always_comb begin
    cand_c = '0;
    for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        cand_c[o][i] = req_switch[i] && (switch_outport[i] == OPW'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_arb
    rr_arbiter #(.N(NUM_BUFFERS)) u_arb (
      .req     (cand_c[o]),
      .ptr     (rr_q[o]),
      .gnt_c   (arb_gnt_c[o]),
      .idx_c   (arb_idx_c[o]),
      .valid_c (arb_valid_c[o])
    );
  end

  // Next-state logic for all outport FSMs, pointers, owners and grant pulses.
  always_comb begin
    for (int unsigned o = 0; o < NUM_OUTPORTS; o++) state_n[o] = state_q[o];
    owner_n = outport_owner;
    rr_n    = rr_q;
    gnt_n   = '0;
`ifdef SWITCH_ALLOC_WATCHDOG_EN
    cnt_n   = cnt_q;
    err_n   = timeout_err;
`endif
    for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
      case (state_q[o])
        FREE: begin
          if (arb_valid_c[o] && outport_credit[o]) begin
            state_n[o] = LOCKED;
            owner_n[o] = arb_idx_c[o];
            rr_n[o]    = (arb_idx_c[o] == BW'(NUM_BUFFERS - 1)) ? '0
                                                                : BW'(arb_idx_c[o] + BW'(1));
            gnt_n      = gnt_n | arb_gnt_c[o];
`ifdef SWITCH_ALLOC_WATCHDOG_EN
            cnt_n[o]   = '0;
`endif
          end
        end
        LOCKED: begin
          if (packet_done[outport_owner[o]]) begin
            state_n[o] = FREE;
          end
`ifdef SWITCH_ALLOC_WATCHDOG_EN
          // The edge that closes the TIMEOUT-th locked cycle forces the release.
          else if (CW'(cnt_q[o] + CW'(1)) == CW'(TIMEOUT)) begin
            state_n[o] = FREE;
            err_n[o]   = 1'b1;
          end else begin
            cnt_n[o] = CW'(cnt_q[o] + CW'(1));
          end
`endif
        end
        default: state_n[o] = FREE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned o = 0; o < NUM_OUTPORTS; o++) state_q[o] <= FREE;
      outport_owner  <= '0;
      rr_q           <= '0;
      switch_granted <= '0;
`ifdef SWITCH_ALLOC_WATCHDOG_EN
      cnt_q          <= '0;
      timeout_err    <= '0;
`endif
    end else begin
      for (int unsigned o = 0; o < NUM_OUTPORTS; o++) state_q[o] <= state_n[o];
      outport_owner  <= owner_n;
      rr_q           <= rr_n;
      switch_granted <= gnt_n;
`ifdef SWITCH_ALLOC_WATCHDOG_EN
      cnt_q          <= cnt_n;
      timeout_err    <= err_n;
`endif
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
      outport_busy[o] = (state_q[o] == LOCKED);
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus randomized traffic vs a behavioural model.
module tb_switch_allocator;

  localparam int NB  = 5;
  localparam int NO  = 5;
  localparam int OPW = 3;
  localparam int BW  = 3;
  localparam int TO  = 8;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [NB-1:0]           req;
  logic [NB-1:0][OPW-1:0]  outp;
  logic [NB-1:0]           pd;
  logic [NO-1:0]           credit;
  logic [NB-1:0]           gnt;
  logic [NO-1:0]           busy;
  logic [NO-1:0][BW-1:0]   owner;
`ifdef SWITCH_ALLOC_WATCHDOG_EN
  logic [NO-1:0]           terr;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state.
  bit            m_locked [NO];
  int            m_owner  [NO];
  int            m_ptr    [NO];
  int            m_lcnt   [NO];
  bit            m_err    [NO];
  logic [NB-1:0] m_grant;

  always #5 CLK = ~CLK;

  switch_allocator #(
    .NUM_BUFFERS (NB),
    .NUM_OUTPORTS(NO)
`ifdef SWITCH_ALLOC_WATCHDOG_EN
    , .TIMEOUT   (TO)
`endif
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .req_switch     (req),
    .switch_outport (outp),
    .packet_done    (pd),
    .outport_credit (credit),
    .switch_granted (gnt),
    .outport_busy   (busy),
    .outport_owner  (owner)
`ifdef SWITCH_ALLOC_WATCHDOG_EN
    , .timeout_err  (terr)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin
      m_locked[o] = 0; m_owner[o] = 0; m_ptr[o] = 0; m_lcnt[o] = 0; m_err[o] = 0;
    end
    m_grant = '0;
  endtask

  // One clock edge of the allocator, straight from the rules.
  task automatic model_step();
    logic [NB-1:0] g;
    bit found;
    int b;
    g = '0;
    for (int o = 0; o < NO; o++) begin
      if (!m_locked[o]) begin
        found = 0;
        if (credit[o]) begin
          for (int k = 0; k < NB; k++) begin
            b = (m_ptr[o] + k) % NB;
            if (!found && req[b] && int'(outp[b]) == o) begin
              found = 1;
              m_locked[o] = 1;
              m_owner[o]  = b;
              m_ptr[o]    = (b + 1) % NB;
              m_lcnt[o]   = 0;
              g[b]        = 1'b1;
            end
          end
        end
      end else begin
        m_lcnt[o]++;
        if (pd[m_owner[o]]) m_locked[o] = 0;
`ifdef SWITCH_ALLOC_WATCHDOG_EN
        else if (m_lcnt[o] == TO) begin
          m_locked[o] = 0;
          m_err[o]    = 1;
        end
`endif
      end
    end
    m_grant = g;
  endtask

  task automatic compare();
    chk("switch_granted", int'(gnt), int'(m_grant));
    for (int o = 0; o < NO; o++) begin
      chk($sformatf("outport_busy[%0d]", o), int'(busy[o]), int'(m_locked[o]));
      chk($sformatf("outport_owner[%0d]", o), int'(owner[o]), m_owner[o]);
`ifdef SWITCH_ALLOC_WATCHDOG_EN
      chk($sformatf("timeout_err[%0d]", o), int'(terr[o]), int'(m_err[o]));
`endif
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RST) model_step();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    req = '0; pd = '0; credit = '1;
    for (int i = 0; i < NB; i++) outp[i] = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST = 1'b1;
    model_reset();
    #1;
    compare();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic int oh2i(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int order[$];
    int gi;

    // Single request and release.
    apply_reset();
    chk("reset busy", int'(busy), 0);
    req[2] = 1'b1; outp[2] = 3'd1;
    tick();
    chk("single grant", int'(gnt), 5'b00100);
    chk("single owner", int'(owner[1]), 2);
    chk("single busy", int'(busy[1]), 1);
    req = '0;
    tick();
    chk("grant one cycle", int'(gnt), 0);
    repeat (3) tick();
    chk("held busy", int'(busy[1]), 1);
    pd[2] = 1'b1;
    tick();
    pd = '0;
    chk("released busy", int'(busy[1]), 0);

    // Contention rotation on outport 0.
    apply_reset();
    req = 5'b01011;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      tick();
      pd = '0;
      gi = oh2i(gnt);
      if (gi >= 0) begin
        order.push_back(gi);
        pd[gi] = 1'b1;
      end
    end
    pd = '0; req = '0;
    chk("rotation count", order.size(), 4);
    if (order.size() == 4) begin
      chk("rotation 0", order[0], 0);
      chk("rotation 1", order[1], 1);
      chk("rotation 2", order[2], 3);
      chk("rotation 3", order[3], 0);
    end

    // Credit gate.
    apply_reset();
    credit[2] = 1'b0; req[4] = 1'b1; outp[4] = 3'd2;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("credit gated", int'(gnt), 0);
    end
    credit[2] = 1'b1;
    tick();
    chk("credit grant", int'(gnt), 5'b10000);
    req = '0;

    // Non-owner done is ignored.
    apply_reset();
    req[1] = 1'b1; outp[1] = 3'd3;
    tick();
    req = '0; pd[0] = 1'b1;
    tick();
    pd = '0;
    chk("nonowner busy", int'(busy[3]), 1);
    chk("nonowner owner", int'(owner[3]), 1);

    // Reset mid-packet.
    apply_reset();
    req = 5'b01010; outp[3] = 3'd0; outp[1] = 3'd2;
    tick();
    chk("two grants", int'(gnt), 5'b01010);
    chk("two busy", int'(busy), 5'b00101);
    req = '0;
    tick();
    RST = 1'b1;
    model_reset();
    #1;
    chk("async busy", int'(busy), 0);
    chk("async owner", int'(owner), 0);
    chk("async grant", int'(gnt), 0);
    @(negedge CLK);
    RST = 1'b0;
    req = '1;
    for (int i = 0; i < NB; i++) outp[i] = 3'd0;
    tick();
    chk("post reset winner", int'(gnt), 5'b00001);
    req = '0;

`ifdef SWITCH_ALLOC_WATCHDOG_EN
    // Watchdog releases after TO locked cycles and the error sticks.
    apply_reset();
    req[0] = 1'b1; outp[0] = 3'd1;
    tick();
    req = '0;
    for (int c = 0; c < TO - 1; c++) tick();
    chk("wd still locked", int'(busy[1]), 1);
    tick();
    chk("wd released", int'(busy[1]), 0);
    chk("wd err", int'(terr), 5'b00010);
    repeat (3) tick();
    chk("wd err sticky", int'(terr[1]), 1);
`endif

    // Randomized traffic including out-of-range outports and one async reset.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        req[i]  = ($urandom_range(0, 1) == 1);
        outp[i] = 3'($urandom_range(0, 7));
        pd[i]   = ($urandom_range(0, 3) == 0);
      end
      for (int o = 0; o < NO; o++) credit[o] = ($urandom_range(0, 7) != 0);
      if (c == 1500) begin
        RST = 1'b1;
        model_reset();
        #1;
        compare();
        @(negedge CLK);
        RST = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-outport switch allocator for the chiplet switch. It takes the switch-allocation requests raised by the input buffers and grants each output port to at most one input buffer, choosing by round-robin. The granted port stays locked to that buffer for the whole packet and is released on the tail flit. It sits between the input buffer block (req_switch / switch_outport / switch_granted) and the crossbar, whose per-outport select it drives.

## Interface
Parameters:
- NUM_BUFFERS, 5: number of input buffers (requesters).
- NUM_OUTPORTS, 5: number of crossbar output ports.
- TIMEOUT, 1024: lock watchdog limit in cycles; only used when the watchdog is compiled in.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset. One clock; reset is asynchronous and active-high.
- req_switch  in  NUM_BUFFERS  buffer i requests switch allocation.
- switch_outport  in  NUM_BUFFERS x $clog2(NUM_OUTPORTS)  requested outport per buffer.
- packet_done  in  NUM_BUFFERS  buffer i reads its tail flit this cycle.
- outport_credit  in  NUM_OUTPORTS  downstream has space on this outport.
- switch_granted  out  NUM_BUFFERS  one-cycle grant pulse to buffer i.
- outport_busy  out  NUM_OUTPORTS  outport is locked to an owner.
- outport_owner  out  NUM_OUTPORTS x $clog2(NUM_BUFFERS)  crossbar select per outport.
- timeout_err  out  NUM_OUTPORTS  sticky watchdog flag; exists only with the watchdog compiled in.

## Operation
- Each outport has an independent FSM with states FREE and LOCKED, plus a round-robin pointer rr_ptr of width $clog2(NUM_BUFFERS).
- Candidates for outport o: buffers with req_switch[i]=1 and switch_outport[i]=o.
- Requests with switch_outport >= NUM_OUTPORTS are ignored and never granted.
- FREE: if there is at least one candidate and outport_credit[o]=1, the winner is the first candidate at or after rr_ptr, wrapping modulo NUM_BUFFERS. On the next edge:
  - state becomes LOCKED;
  - owner is set to the winner;
  - rr_ptr is set to (winner+1) mod NUM_BUFFERS;
  - switch_granted[winner] pulses high for one cycle.
- With no candidates, or outport_credit[o]=0, the outport stays FREE and no grant is issued.
- LOCKED: no arbitration. If packet_done[owner]=1, the outport becomes FREE on the next edge. packet_done from any non-owner buffer is ignored.
- Each buffer requests only one outport at a time, so at most one outport can grant a given buffer in a cycle. switch_granted is the OR over outports.
- A buffer that still holds req_switch during its grant cycle is not re-granted, because the outport is already LOCKED.

## Timing
- Reset values:
  - all outports FREE;
  - rr_ptr = 0;
  - owner = 0;
  - switch_granted = 0;
  - outport_busy = 0;
  - timeout_err = 0.
- Reset asserted mid-packet drops every lock immediately, with no pending grant.
- Grant latency: a request sampled at edge N gives switch_granted high during cycle N+1 (registered output). outport_busy and outport_owner are valid from N+1.
- Release: packet_done at edge M gives FREE from M+1. The earliest new grant pulse is at M+2.
- packet_done during the grant cycle itself is legal and releases at the next edge.
- Simultaneous requests from all buffers to the same outport are served in strict rotation: each buffer is granted once per NUM_BUFFERS packets.

## Configuration
- SWITCH_ALLOC_WATCHDOG_EN defined:
  - each outport has a $clog2(TIMEOUT+1)-bit counter that clears on entering LOCKED and increments each LOCKED cycle;
  - when the counter reaches TIMEOUT, the outport is forced FREE on the next edge and timeout_err[o] is set;
  - timeout_err[o] is sticky and cleared only by RST.
- Macro undefined: no counters and no timeout_err port. A lock is held until packet_done.

## Structure
- The outport FSM state enum (FREE, LOCKED) goes in chiplet_types_pkg as alloc_state_t.
- One sub-module, rr_arbiter #(N): combinational request vector plus pointer in, one-hot grant and index out. It is instantiated once per outport.
- FSM, pointers, owners and watchdog stay in switch_allocator.

## Test plan
- Single request: buffer 2 requests outport 1 at edge 0 -> switch_granted = 5'b00100 in cycle 1 only; outport_owner[1]=2; outport_busy[1]=1. packet_done[2] at edge 5 -> outport_busy[1]=0 from cycle 6.
- Contention: buffers 0, 1, 3 hold requests to outport 0, each sending packet_done one cycle after its grant -> grant order 0, 1, 3, 0; rr_ptr follows 1, 2, 4, 1.
- Credit gate: outport_credit[2]=0 while buffer 4 requests outport 2 for 10 cycles -> no grant. Raise credit -> grant one cycle later.
- Non-owner release: outport 3 locked to buffer 1, packet_done[0] pulses -> outport stays LOCKED with owner 1.
- Reset mid-packet: assert RST while outports 0 and 2 are LOCKED -> all outputs return to reset values immediately. After release, buffer 0 wins the first arbitration.
- Watchdog (SWITCH_ALLOC_WATCHDOG_EN, TIMEOUT=8): lock outport 1 with no packet_done -> FREE after 8 LOCKED cycles; timeout_err[1] is set and stays set.
